exec_window_checker: RTL

// - Consumes the free-running execution cycle count and measures elapsed cycles of marked code regions (start/end strobes).
// - Checks each window against lower/upper cycle bounds; raises a sticky alarm on short, long or malformed windows.
// - Sits directly downstream of the execution cycle counter; feeds the detection alarm/reporting logic.

---
 rtl/exec_window_checker.sv | 98 +++++++++
 1 files changed

// File: rtl/exec_window_checker.sv
// exec_window_checker: times start/end-marked code regions against per-window
// cycle bounds and raises a sticky alarm on short, long or malformed windows.
// Optional feature: define EXEC_WIN_MINMAX_EN to add out_min_delta/out_max_delta.
module exec_window_checker #(
   parameter int CW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             in_clk,
   input  logic             in_reset,
   input  logic [CW-1:0]    in_cycle,
   input  logic             in_start,
   input  logic             in_end,
   input  logic [CW-1:0]    in_lo_bound,
   input  logic [CW-1:0]    in_hi_bound,
   input  logic             in_alarm_clear,
   output logic             out_busy,
   output logic             out_valid,
   output logic [CW-1:0]    out_delta,
   output logic             out_alarm,
   output logic [1:0]       out_alarm_code,
   output logic [CNT_W-1:0] out_win_count
`ifdef EXEC_WIN_MINMAX_EN
   ,
   output logic [CW-1:0]    out_min_delta,
   output logic [CW-1:0]    out_max_delta
`endif
);
   typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_t;
   state_t state, state_n;
   logic [CW-1:0] stamp, lo, hi, elapsed;
   logic complete, proto, short_w, long_w;
   logic [1:0] code_n;
   // State register
   always_ff @(posedge in_clk)
      state <= in_reset ? IDLE : state_n;
   // Next state, window completion and alarm classification (wrap-safe elapsed)
   always_comb begin
      elapsed  = in_cycle - stamp;
      complete = state != IDLE && in_end;
      proto    = state == IDLE ? (in_end && !in_start) : (in_start && !in_end);
      short_w  = complete && elapsed < lo;
      long_w   = state == MEASURE && elapsed > hi;
      code_n   = proto ? 2'b11 : short_w ? 2'b01 : long_w ? 2'b10 : 2'b00;
      state_n  = in_start ? MEASURE :
                 (state == IDLE || in_end) ? IDLE :
                 (state == MEASURE && elapsed > hi) ? TIMEOUT : state;
      out_busy = state != IDLE;
   end
   // Stamp/bounds capture, completion report, sticky alarm and window count
   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         stamp          <= '0;
         lo             <= '0;
         hi             <= '0;
         out_valid      <= 1'b0;
         out_delta      <= '0;
         out_alarm      <= 1'b0;
         out_alarm_code <= 2'b00;
         out_win_count  <= '0;
      end else begin
         out_valid <= complete;
         if (complete) begin
            out_delta     <= elapsed;
            out_win_count <= out_win_count + CNT_W'(!(&out_win_count));
         end
         if (in_start) begin
            stamp <= in_cycle;
            lo    <= in_lo_bound;
            hi    <= in_hi_bound;
         end
         if (code_n != 2'b00 && (!out_alarm || in_alarm_clear)) begin
            out_alarm      <= 1'b1;
            out_alarm_code <= code_n;
         end else if (in_alarm_clear) begin
            out_alarm      <= 1'b0;
            out_alarm_code <= 2'b00;
         end
      end
   end
`ifdef EXEC_WIN_MINMAX_EN
   // Running min/max of completed window lengths; a clear restarts tracking
   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         out_min_delta <= '1;
         out_max_delta <= '0;
      end else begin
         if (in_alarm_clear) begin
            out_min_delta <= '1;
            out_max_delta <= '0;
         end
         if (complete) begin
            if (in_alarm_clear || elapsed < out_min_delta) out_min_delta <= elapsed;
            if (in_alarm_clear || elapsed > out_max_delta) out_max_delta <= elapsed;
         end
      end
   end
`endif
endmodule
